// File: rtl/token_pkg.sv
// Shared constants and helpers for the token-multiplier block and its counter.
package token_pkg;

    localparam int FACTOR_DEFAULT = 2;
    localparam int CNT_W_DEFAULT  = 8;
    // Width of the per-cycle add amount; FACTOR never exceeds 4.
    localparam int ADD_W          = 3;

    function automatic int unsigned max_count(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating counter: adds a small amount and subtracts one per cycle,
// clamping at the all-ones value and flagging the cycle where it clamps.
module sat_updown_counter
    import token_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADD_W-1:0] add,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam int               EXT_W   = CNT_W + 3;
    localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(max_count(CNT_W));

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [EXT_W-1:0] next_ext;

    // Extra headroom bits make the sum exact, so the clamp test cannot wrap.
    always_comb begin
        next_ext = EXT_W'(count_q) + EXT_W'(add) - EXT_W'(dec);
        count_d  = next_ext[CNT_W-1:0];
        sat      = 1'b0;
        if (next_ext > MAX_EXT) begin
            count_d = MAX_EXT[CNT_W-1:0];
            sat     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/double_tokens.sv
// Emits FACTOR output tokens on b for every input token on a, tracking the
// owed tokens in a saturating counter with a sticky overflow flag.
module double_tokens
    import token_pkg::*;
#(
    parameter int FACTOR = FACTOR_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    output logic             b,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    logic [ADD_W-1:0] add;
    logic             sat;
    logic             overflow_q;
    logic             overflow_d;

    assign add = a ? ADD_W'(FACTOR) : '0;

    // The token emitted this cycle is the decrement, so production and
    // consumption settle in the same edge.
    sat_updown_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .add   (add),
        .dec   (b),
        .count (pending),
        .sat   (sat)
    );

    assign b = (pending != '0);

    always_comb begin
        overflow_d = overflow_q | sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule
